// File: rtl/multicycle_controller.sv
// Main control FSM and ALU decoder for the multicycle MIPS core.
// Steps fetch/decode/execute/memory/writeback and drives datapath selects.
//
// Ports:
//   clk        : rising-edge clock
//   reset      : async active-high, forces FETCH
//   op, funct  : opcode / function field from the instruction register
//   zero       : ALU zero flag, consulted only in BRANCH
//   memwrite   : memory write strobe
//   irwrite    : instruction register load enable
//   lord       : address select (0 pc, 1 aluout)
//   regdst     : write register select (0 rt, 1 rd)
//   memtoreg   : writeback select (0 aluout, 1 data reg)
//   regwrite   : register file write enable
//   alusrca    : ALU A select (0 pc, 1 A reg)
//   alusrcb    : ALU B select (B, 4, signimm, signimm<<2)
//   alucontrol : ALU operation
//   pcen       : pc register enable
//   pcsrc      : next pc select (aluresult, aluout, jump)
module multicycle_controller #(
  parameter int ENABLE_BNE = 1,
  parameter int STATE_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       irwrite,
  output logic       lord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [1:0] pcsrc
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMRD    = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWR    = STATE_W'(5),
    S_EXECUTE  = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_BRANCH   = STATE_W'(8),
    S_ADDIEXEC = STATE_W'(9),
    S_ADDIWB   = STATE_W'(10),
    S_JUMP     = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_branch;
  logic       w_pcwrite;
  logic       w_taken;
  logic       w_bad_state;
  logic [2:0] w_alu_dec;

  logic w_is_lw;
  logic w_is_sw;
  logic w_is_r;
  logic w_is_beq;
  logic w_is_bne;
  logic w_is_addi;
  logic w_is_j;
  logic w_is_mem;

  assign w_is_lw   = (op == OP_LW);
  assign w_is_sw   = (op == OP_SW);
  assign w_is_r    = (op == OP_RTYPE);
  assign w_is_beq  = (op == OP_BEQ);
  assign w_is_bne  = (ENABLE_BNE != 0) && (op == OP_BNE);
  assign w_is_addi = (op == OP_ADDI);
  assign w_is_j    = (op == OP_J);
  assign w_is_mem  = w_is_lw | w_is_sw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    lord        = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    w_aluop     = 2'b00;
    w_branch    = 1'b0;
    w_pcwrite   = 1'b0;
    w_bad_state = 1'b0;
    case (r_state)
      S_FETCH: begin
        irwrite   = 1'b1;
        alusrcb   = 2'b01;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here into aluout.
        alusrcb = 2'b11;
        unique case (1'b1)
          w_is_mem:              w_next = S_MEMADR;
          w_is_r:                w_next = S_EXECUTE;
          w_is_beq || w_is_bne:  w_next = S_BRANCH;
          w_is_addi:             w_next = S_ADDIEXEC;
          w_is_j:                w_next = S_JUMP;
          default:               w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = w_is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        lord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        lord     = 1'b1;
        memwrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      default: begin
        w_bad_state = 1'b1;
        w_next      = S_FETCH;
      end
    endcase
  end

  always_comb begin
    w_alu_dec = ALU_ADD;
    case (w_aluop)
      2'b00: w_alu_dec = ALU_ADD;
      2'b01: w_alu_dec = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100000: w_alu_dec = ALU_ADD;
          6'b100010: w_alu_dec = ALU_SUB;
          6'b100100: w_alu_dec = ALU_AND;
          6'b100101: w_alu_dec = ALU_OR;
          6'b101010: w_alu_dec = ALU_SLT;
          // Unknown funct still writes back, as an add.
          default:   w_alu_dec = ALU_ADD;
        endcase
      end
      default: w_alu_dec = ALU_ADD;
    endcase
  end

  // Stray encodings present an all-zero control word.
  assign alucontrol = w_bad_state ? 3'b000 : w_alu_dec;

  // bne only exists when enabled; otherwise it never reaches BRANCH.
  assign w_taken = w_is_beq ? zero : (w_is_bne ? ~zero : 1'b0);
  assign pcen    = w_pcwrite | (w_branch & w_taken);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller.
// Directed instruction sequences; expected control words queued and checked.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       memwrite, irwrite, lord, regdst, memtoreg, regwrite;
  logic       alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  always #5 clk = ~clk;

  multicycle_controller #(
    .ENABLE_BNE(1),
    .STATE_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .op(op),
    .funct(funct),
    .zero(zero),
    .memwrite(memwrite),
    .irwrite(irwrite),
    .lord(lord),
    .regdst(regdst),
    .memtoreg(memtoreg),
    .regwrite(regwrite),
    .alusrca(alusrca),
    .alusrcb(alusrcb),
    .alucontrol(alucontrol),
    .pcen(pcen),
    .pcsrc(pcsrc)
  );

  // {mw,irw,lord,rdst,m2r,rw,asel,bsel[2],alu[3],pcen,pcsrc[2]}
  logic [14:0] act;
  assign act = {memwrite, irwrite, lord, regdst, memtoreg, regwrite,
                alusrca, alusrcb, alucontrol, pcen, pcsrc};

  typedef struct {
    logic [14:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [2:0] fdec(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [14:0] vec(int s, logic [5:0] o,
                                      logic [5:0] f, logic z);
    logic mw, irw, ld, rd, m2r, rw, as, pe;
    logic [1:0] bs, ps;
    logic [2:0] al;
    {mw, irw, ld, rd, m2r, rw, as, pe} = 8'b0;
    bs = 2'b00;
    ps = 2'b00;
    al = 3'b010;
    case (s)
      0:  begin irw = 1; bs = 2'b01; pe = 1; end
      1:  bs = 2'b11;
      2:  begin as = 1; bs = 2'b10; end
      3:  ld = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin ld = 1; mw = 1; end
      6:  begin as = 1; al = fdec(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin
        as = 1; al = 3'b110; ps = 2'b01;
        pe = (o == 6'b000100) ? z : ~z;
      end
      9:  begin as = 1; bs = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {mw, irw, ld, rd, m2r, rw, as, bs, al, pe, ps};
  endfunction

  task automatic check(logic [14:0] e, string nm);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, e);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.v, e.nm);
    end
  end

  function automatic int hexd(byte c);
    if (c >= "a") return int'(c) - int'("a") + 10;
    return int'(c) - int'("0");
  endfunction

  // Called just after a posedge; leaves just after a posedge.
  task automatic run(string nm, logic [5:0] o, logic [5:0] f,
                     logic z, string path);
    exp_t e;
    op = o;
    funct = f;
    zero = z;
    for (int i = 0; i < path.len(); i++) begin
      e.v  = vec(hexd(path[i]), o, f, z);
      e.nm = $sformatf("%s[%0d]", nm, i);
      q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e;
    #2;
    check(vec(0, 6'd0, 6'd0, 1'b0), "reset_fetch");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // sw up to MEMWR, then abort with reset mid-cycle
    run("sw_pre", 6'b101011, 6'd0, 1'b0, "012");
    e.v  = vec(5, 6'b101011, 6'd0, 1'b0);
    e.nm = "sw_memwr";
    q.push_back(e);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check(vec(0, 6'b101011, 6'd0, 1'b0), "rst_async_memwr");
    @(posedge clk);
    #1;
    e.v  = vec(0, 6'd0, 6'd0, 1'b0);
    e.nm = "rst_hold";
    q.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run("lw",      6'b100011, 6'd0,      1'b1, "01234");
    run("sw",      6'b101011, 6'd0,      1'b1, "0125");
    run("r_slt",   6'b000000, 6'b101010, 1'b0, "0167");
    run("r_and",   6'b000000, 6'b100100, 1'b1, "0167");
    run("r_add",   6'b000000, 6'b100000, 1'b0, "0167");
    run("r_sub",   6'b000000, 6'b100010, 1'b0, "0167");
    run("r_or",    6'b000000, 6'b100101, 1'b0, "0167");
    run("r_unk",   6'b000000, 6'b111111, 1'b0, "0167");
    run("beq_t",   6'b000100, 6'd0,      1'b1, "018");
    run("beq_nt",  6'b000100, 6'd0,      1'b0, "018");
    run("bne_nt",  6'b000101, 6'd0,      1'b1, "018");
    run("bne_t",   6'b000101, 6'd0,      1'b0, "018");
    run("j",       6'b000010, 6'd0,      1'b0, "01b");
    run("addi",    6'b001000, 6'd0,      1'b1, "019a");
    run("ill",     6'b111111, 6'd0,      1'b1, "01");
    run("ill2",    6'b001100, 6'd0,      1'b0, "01");
    run("lw2",     6'b100011, 6'd0,      1'b0, "012340");

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
